// File: rtl/axi_xbar_wr_arbiter.sv
// axi_xbar_wr_arbiter: shares one downstream AXI write port among NUM_REQ requesters
// (round-robin AW, W steered in AW grant order, B routed by ID prefix).
module axi_xbar_wr_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ID_WIDTH     = 4,
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int W_FIFO_DEPTH = 4,
  localparam int IDX_W = $clog2(NUM_REQ),
  localparam int OID_W = ID_WIDTH + IDX_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_aw_valid,
  output logic [NUM_REQ-1:0]               req_aw_ready,
  input  logic [NUM_REQ*ID_WIDTH-1:0]      req_aw_id,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_aw_addr,
  input  logic [NUM_REQ*8-1:0]             req_aw_len,
  input  logic [NUM_REQ-1:0]               req_w_valid,
  input  logic [NUM_REQ-1:0]               req_w_last,
  output logic [NUM_REQ-1:0]               req_w_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_w_data,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]  req_w_strb,
  output logic [NUM_REQ-1:0]               req_b_valid,
  input  logic [NUM_REQ-1:0]               req_b_ready,
  output logic [ID_WIDTH-1:0]              req_b_id,
  output logic [1:0]                       req_b_resp,
  output logic                             m_aw_valid,
  input  logic                             m_aw_ready,
  output logic [OID_W-1:0]                 m_aw_id,
  output logic [ADDR_WIDTH-1:0]            m_aw_addr,
  output logic [7:0]                       m_aw_len,
  output logic                             m_w_valid,
  input  logic                             m_w_ready,
  output logic                             m_w_last,
  output logic [DATA_WIDTH-1:0]            m_w_data,
  output logic [DATA_WIDTH/8-1:0]          m_w_strb,
  input  logic                             m_b_valid,
  output logic                             m_b_ready,
  input  logic [OID_W-1:0]                 m_b_id,
  input  logic [1:0]                       m_b_resp,
  output logic                             bad_bid_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int PTR_W  = (W_FIFO_DEPTH > 1) ? $clog2(W_FIFO_DEPTH) : 1;

  logic [ID_WIDTH-1:0]   w_aw_id   [NUM_REQ];
  logic [ADDR_WIDTH-1:0] w_aw_addr [NUM_REQ];
  logic [7:0]            w_aw_len  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_w_data  [NUM_REQ];
  logic [STRB_W-1:0]     w_w_strb  [NUM_REQ];

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_aw_id[g]   = req_aw_id[g*ID_WIDTH +: ID_WIDTH];
    assign w_aw_addr[g] = req_aw_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_aw_len[g]  = req_aw_len[g*8 +: 8];
    assign w_w_data[g]  = req_w_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_w_strb[g]  = req_w_strb[g*STRB_W +: STRB_W];
  end

  logic                  r_aw_full;
  logic [OID_W-1:0]      r_aw_id;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [7:0]            r_aw_len;
  logic [IDX_W-1:0]      r_rr;
  logic [IDX_W-1:0]      r_fifo [W_FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wp, r_rp;
  logic [PTR_W:0]        r_cnt;
  logic                  r_bad;

  logic             w_any, w_grant, w_ne, w_pop, w_sel_ok;
  logic [IDX_W-1:0] w_win, w_idx, w_head, w_sel;

  // Scan from the highest offset down so the offset closest to r_rr is the last writer.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = IDX_W'((int'(r_rr) + i) % NUM_REQ);
      if (req_aw_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  // Grant is gated by rst_n so req_aw_ready reads 0 throughout an asynchronous reset.
  assign w_grant      = rst_n && w_any && (!r_aw_full || m_aw_ready) && (r_cnt != (PTR_W+1)'(W_FIFO_DEPTH));
  assign req_aw_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;
  assign m_aw_valid   = r_aw_full;
  assign m_aw_id      = r_aw_id;
  assign m_aw_addr    = r_aw_addr;
  assign m_aw_len     = r_aw_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_full <= 1'b0;
      r_aw_id   <= '0;
      r_aw_addr <= '0;
      r_aw_len  <= '0;
      r_rr      <= '0;
    end else if (w_grant) begin
      r_aw_full <= 1'b1;
      r_aw_id   <= {w_win, w_aw_id[w_win]};
      r_aw_addr <= w_aw_addr[w_win];
      r_aw_len  <= w_aw_len[w_win];
      r_rr      <= (w_win == IDX_W'(NUM_REQ - 1)) ? '0 : w_win + IDX_W'(1);
    end else if (m_aw_ready) begin
      r_aw_full <= 1'b0;
    end
  end

  assign w_ne        = r_cnt != '0;
  assign w_head      = r_fifo[r_rp];
  assign m_w_valid   = w_ne && req_w_valid[w_head];
  assign m_w_last    = req_w_last[w_head];
  assign m_w_data    = w_w_data[w_head];
  assign m_w_strb    = w_w_strb[w_head];
  assign req_w_ready = (w_ne && m_w_ready) ? (NUM_REQ'(1) << w_head) : '0;
  assign w_pop       = m_w_valid && m_w_ready && m_w_last;

  always_ff @(posedge clk) begin
    if (w_grant) r_fifo[r_wp] <= w_win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_grant ? r_wp + PTR_W'(1) : r_wp;
      r_rp  <= w_pop ? r_rp + PTR_W'(1) : r_rp;
      r_cnt <= r_cnt + (PTR_W+1)'(w_grant) - (PTR_W+1)'(w_pop);
    end
  end

  assign w_sel       = m_b_id[OID_W-1:ID_WIDTH];
  assign w_sel_ok    = {1'b0, w_sel} < (IDX_W+1)'(NUM_REQ);
  assign req_b_valid = (m_b_valid && w_sel_ok) ? (NUM_REQ'(1) << w_sel) : '0;
  assign m_b_ready   = w_sel_ok ? req_b_ready[w_sel] : 1'b1;
  assign req_b_id    = m_b_id[ID_WIDTH-1:0];
  assign req_b_resp  = m_b_resp;
  assign bad_bid_o   = r_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bad <= 1'b0;
    else        r_bad <= m_b_valid && !w_sel_ok;
  end
endmodule

// File: tb/tb_axi_xbar_wr_arbiter.sv
// tb_axi_xbar_wr_arbiter: directed scenarios plus random traffic checked against a
// queue-based model of the arbiter's grant, W-order and B-routing rules.
module tb_axi_xbar_wr_arbiter;
  localparam int NR = 3, IDW = 4, AW = 32, DW = 32, DEPTH = 4, OIDW = 6, SW = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0]      req_aw_valid, req_aw_ready, req_w_valid, req_w_last, req_w_ready;
  logic [NR-1:0]      req_b_valid, req_b_ready;
  logic [NR*IDW-1:0]  req_aw_id;
  logic [NR*AW-1:0]   req_aw_addr;
  logic [NR*8-1:0]    req_aw_len;
  logic [NR*DW-1:0]   req_w_data;
  logic [NR*SW-1:0]   req_w_strb;
  logic [IDW-1:0]     req_b_id;
  logic [1:0]         req_b_resp, m_b_resp;
  logic               m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last;
  logic               m_b_valid, m_b_ready, bad_bid_o;
  logic [OIDW-1:0]    m_aw_id, m_b_id;
  logic [AW-1:0]      m_aw_addr;
  logic [7:0]         m_aw_len;
  logic [DW-1:0]      m_w_data;
  logic [SW-1:0]      m_w_strb;

  axi_xbar_wr_arbiter #(.NUM_REQ(NR), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                        .W_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_aw_valid(req_aw_valid), .req_aw_ready(req_aw_ready), .req_aw_id(req_aw_id),
    .req_aw_addr(req_aw_addr), .req_aw_len(req_aw_len),
    .req_w_valid(req_w_valid), .req_w_last(req_w_last), .req_w_ready(req_w_ready),
    .req_w_data(req_w_data), .req_w_strb(req_w_strb),
    .req_b_valid(req_b_valid), .req_b_ready(req_b_ready), .req_b_id(req_b_id),
    .req_b_resp(req_b_resp),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id),
    .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_last(m_w_last),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .bad_bid_o(bad_bid_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit              m_full, m_bad;
  logic [OIDW-1:0] m_id;
  logic [AW-1:0]   m_addr;
  logic [7:0]      m_len;
  int              m_rr;
  int              q[$];
  int              glog[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_bad = 0; m_id = '0; m_addr = '0; m_len = '0; m_rr = 0;
    q.delete();
  endtask

  // One cycle: compare the DUT against the model at the current inputs, advance the model, move to the next negedge.
  task automatic step();
    int k, h, sel;
    bit grant, pop;
    logic [NR-1:0] e_wr, e_bv;
    #1;
    if (!rst_n) model_reset();
    grant = 0; k = 0; pop = 0;
    if (rst_n && (!m_full || m_aw_ready) && q.size() < DEPTH)
      for (int o = 0; o < NR; o++)
        if (!grant && req_aw_valid[(m_rr + o) % NR]) begin grant = 1; k = (m_rr + o) % NR; end
    chk("aw_ready", req_aw_ready, grant ? (NR'(1) << k) : '0);
    chk("m_aw_valid", m_aw_valid, m_full);
    chk("m_aw_id", m_aw_id, m_id);
    chk("m_aw_addr", m_aw_addr, m_addr);
    chk("m_aw_len", m_aw_len, m_len);
    if (q.size() > 0) begin
      h = q[0];
      chk("m_w_valid", m_w_valid, req_w_valid[h]);
      chk("m_w_data", m_w_data, req_w_data[h*DW +: DW]);
      chk("m_w_strb", m_w_strb, req_w_strb[h*SW +: SW]);
      chk("m_w_last", m_w_last, req_w_last[h]);
      e_wr = m_w_ready ? (NR'(1) << h) : '0;
      pop = req_w_valid[h] && m_w_ready && req_w_last[h];
    end else begin
      chk("m_w_valid_empty", m_w_valid, 1'b0);
      e_wr = '0;
    end
    chk("w_ready", req_w_ready, e_wr);
    sel = int'(m_b_id[OIDW-1:IDW]);
    if (sel < NR) begin
      chk("m_b_ready", m_b_ready, req_b_ready[sel]);
      chk("b_id", req_b_id, m_b_id[IDW-1:0]);
      chk("b_resp", req_b_resp, m_b_resp);
      e_bv = m_b_valid ? (NR'(1) << sel) : '0;
    end else begin
      chk("m_b_ready_bad", m_b_ready, 1'b1);
      e_bv = '0;
    end
    chk("b_valid", req_b_valid, e_bv);
    chk("bad_bid", bad_bid_o, m_bad);
    if (rst_n) begin
      if (pop) void'(q.pop_front());
      if (grant) begin
        q.push_back(k);
        glog.push_back(k);
        m_full = 1;
        m_id   = {2'(k), req_aw_id[k*IDW +: IDW]};
        m_addr = req_aw_addr[k*AW +: AW];
        m_len  = req_aw_len[k*8 +: 8];
        m_rr   = (k + 1) % NR;
      end else if (m_aw_ready) m_full = 0;
      m_bad = m_b_valid && sel >= NR;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    req_aw_valid = '0; req_w_valid = '0; req_w_last = '0; m_b_valid = 0;
    req_b_ready = '0; m_aw_ready = 0; m_w_ready = 0; m_b_id = '0; m_b_resp = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    glog.delete();
  endtask

  initial begin
    req_aw_id = '0; req_aw_addr = '0; req_aw_len = '0; req_w_data = '0; req_w_strb = '0;
    idle();
    model_reset();
    do_reset();

    // single burst from requester 0
    req_aw_valid = 3'b001; req_aw_id[3:0] = 4'd3; req_aw_addr[31:0] = 32'h1000;
    req_aw_len[7:0] = 8'd3; m_aw_ready = 1;
    step();
    chk("sb_aw_id", m_aw_id, 6'h03);
    req_aw_valid = '0; req_w_valid = 3'b001; m_w_ready = 1;
    for (int b = 0; b < 4; b++) begin
      req_w_data[31:0] = 32'hA000 + b;
      req_w_last = (b == 3) ? 3'b001 : 3'b000;
      step();
    end
    chk("sb_fifo_empty", m_w_valid, 1'b0);

    // round robin between requesters 0 and 1
    idle(); do_reset();
    req_aw_valid = 3'b011; m_aw_ready = 1; m_w_ready = 1;
    req_w_valid = 3'b011; req_w_last = 3'b011;
    for (int c = 0; c < 6; c++) step();
    chk("rr_count", glog.size(), 6);
    for (int i = 0; i < 6 && i < glog.size(); i++) chk("rr_order", glog[i], i % 2);

    // W-order FIFO full
    idle(); do_reset();
    req_aw_valid = 3'b111; m_aw_ready = 1;
    for (int c = 0; c < 6; c++) step();
    chk("ff_grants", glog.size(), 4);
    req_w_valid = 3'b001; req_w_last = 3'b001; m_w_ready = 1;
    step();
    chk("ff_no_grant_on_pop", glog.size(), 4);
    req_w_valid = '0; m_w_ready = 0;
    step();
    chk("ff_fifth_grant", glog.size(), 5);

    // B routing and bad prefix
    idle();
    m_b_valid = 1; m_b_id = {2'd1, 4'h9}; m_b_resp = 2'd2; req_b_ready = 3'b101;
    #1;
    chk("b_route_v", req_b_valid, 3'b010);
    chk("b_route_id", req_b_id, 4'h9);
    chk("b_route_rdy", m_b_ready, 1'b0);
    step();
    m_b_id = {2'd3, 4'h5};
    step();
    m_b_valid = 0;
    step();
    step();

    // reset in the middle of a burst
    idle(); do_reset();
    req_aw_valid = 3'b001; req_aw_len[7:0] = 8'd3; m_aw_ready = 1;
    step();
    req_aw_valid = '0; req_w_valid = 3'b001; m_w_ready = 1;
    step(); step();
    req_aw_valid = 3'b100;
    rst_n = 0;
    step();
    chk("rst_w_ready", req_w_ready, 3'b000);
    chk("rst_aw_ready", req_aw_ready, 3'b000);
    step();
    rst_n = 1;
    glog.delete();
    step();
    chk("rst_fresh_grant", glog.size(), 1);
    step();

    // random traffic
    idle();
    for (int c = 0; c < 3000; c++) begin
      req_aw_valid = 3'($urandom);
      req_aw_id    = 12'($urandom);
      req_aw_addr  = {$urandom(), $urandom(), $urandom()};
      req_aw_len   = 24'($urandom);
      req_w_valid  = 3'($urandom);
      req_w_last   = 3'($urandom) & 3'($urandom);
      req_w_data   = {$urandom(), $urandom(), $urandom()};
      req_w_strb   = 12'($urandom);
      m_aw_ready   = ($urandom % 4) != 0;
      m_w_ready    = ($urandom % 3) != 0;
      m_b_valid    = 1'($urandom);
      m_b_id       = 6'($urandom);
      m_b_resp     = 2'($urandom);
      req_b_ready  = 3'($urandom);
      rst_n        = (c % 1000) != 999;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_xbar_wr_arbiter.md
# axi_xbar_wr_arbiter

Write-path arbiter for one slave-side port of the AXI crossbar. It shares a single downstream AXI write port among `NUM_REQ` upstream requesters: round-robin on AW, in-order W steering locked to the AW grant sequence, and B routing by ID prefix. One instance sits in front of each crossbar slave port, after address decode.

## Interface
- `NUM_REQ`, default 2: number of upstream requesters; must be ≥ 2.
- `ID_WIDTH`, default 4: requester-side ID width.
- `ADDR_WIDTH`, default 64: address width.
- `DATA_WIDTH`, default 64: W data width; strobe width is `DATA_WIDTH/8`.
- `W_FIFO_DEPTH`, default 4: maximum number of granted AWs whose W burst is not yet complete; must be a power of 2.
- `IDX_W` (localparam) = `$clog2(NUM_REQ)`; `OID_W` (localparam) = `ID_WIDTH + IDX_W`.

Ports:
- `clk` in, 1: clock, rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `req_aw_valid` in, `NUM_REQ`: per-requester AW valid.
- `req_aw_ready` out, `NUM_REQ`: per-requester AW ready.
- `req_aw_id` in, `NUM_REQ*ID_WIDTH`: packed, requester k at slice k.
- `req_aw_addr` in, `NUM_REQ*ADDR_WIDTH`: packed.
- `req_aw_len` in, `NUM_REQ*8`: packed.
- `req_w_valid` / `req_w_last` in, `NUM_REQ`: W valid / last.
- `req_w_ready` out, `NUM_REQ`: W ready.
- `req_w_data` in, `NUM_REQ*DATA_WIDTH`; `req_w_strb` in, `NUM_REQ*DATA_WIDTH/8`: packed.
- `req_b_valid` out, `NUM_REQ`; `req_b_ready` in, `NUM_REQ`: per-requester B handshake.
- `req_b_id` out, `ID_WIDTH`; `req_b_resp` out, 2: shared B payload.
- `m_aw_valid` out, 1; `m_aw_ready` in, 1; `m_aw_id` out, `OID_W`; `m_aw_addr` out, `ADDR_WIDTH`; `m_aw_len` out, 8.
- `m_w_valid` out, 1; `m_w_ready` in, 1; `m_w_last` out, 1; `m_w_data` out, `DATA_WIDTH`; `m_w_strb` out, `DATA_WIDTH/8`.
- `m_b_valid` in, 1; `m_b_ready` out, 1; `m_b_id` in, `OID_W`; `m_b_resp` in, 2.
- `bad_bid_o` out, 1: one-cycle pulse when a B response with an out-of-range prefix is discarded.

## Operation
- **AW output register (`aw_full`).** The register is loadable when `!aw_full`, or when `m_aw_valid && m_aw_ready` in the same cycle.
- **AW grant.** Requires a loadable register and W-order FIFO not full. A push is refused when the FIFO is full, even if a pop happens that cycle.
  - Winner k is the first set `req_aw_valid` bit scanning from `rr_ptr` upward, wrapping at `NUM_REQ`.
  - `req_aw_ready[k]` is 1 for the grant cycle only; all other bits are 0.
  - The register loads `m_aw_id = {k[IDX_W-1:0], req_aw_id[k]}`, plus addr and len.
  - k is pushed into the W-order FIFO.
  - `rr_ptr <= (k+1) mod NUM_REQ`.
- **No grant.** With no valid requester, `rr_ptr` holds.
- **W steering.** `h` = FIFO head. When the FIFO is non-empty:
  - `m_w_valid = req_w_valid[h]`; data, strb and last are muxed from h.
  - `req_w_ready[h] = m_w_ready`; all other `req_w_ready` bits are 0.
  - When the FIFO is empty, `m_w_valid = 0` and all `req_w_ready = 0`.
  - A handshake beat with `m_w_last = 1` pops the FIFO.
  - Beats are not counted: `req_w_last` is trusted.
- **B routing.**
  - `sel = m_b_id[OID_W-1:ID_WIDTH]`.
  - If `sel < NUM_REQ`: `req_b_valid[sel] = m_b_valid`, `m_b_ready = req_b_ready[sel]`, `req_b_id = m_b_id[ID_WIDTH-1:0]`, `req_b_resp = m_b_resp`.
  - If `sel >= NUM_REQ`: `m_b_ready = 1`, the beat is dropped, and `bad_bid_o` is registered high the next cycle for one cycle.
- **Combinational paths.** B is fully combinational. W is combinational apart from the FIFO state.

## Timing
- **Reset values.** Reset clears `aw_full`, the FIFO pointers/count and `rr_ptr` (to 0). Outputs at reset: `m_aw_valid = 0`, all `req_aw_ready = 0`, `m_w_valid = 0`, all `req_w_ready = 0`, `bad_bid_o = 0`; `m_aw_*` payload is 0.
- **Reset mid-operation.** Reset discards in-flight AW and FIFO entries with no drain. Outstanding upstream bursts are the system's responsibility.
- **AW latency.** Requester AW handshake in cycle N gives `m_aw_valid = 1` in cycle N+1. Sustained throughput is 1 AW/cycle while `m_aw_ready = 1`.
- **AW backpressure.** `m_aw_valid` and payload stay stable until `m_aw_ready`. `req_aw_ready` never depends combinationally on `req_aw_ready` of another port.
- **W after AW.** The earliest W beat for a grant is cycle N+1, since the FIFO push becomes visible after the edge. W may precede `m_aw_valid` downstream.
- **W before AW.** A requester asserting W before its AW grant is stalled (`req_w_ready = 0`).
- **FIFO full.** At `W_FIFO_DEPTH` entries no AW is granted. Once the last beat pops, a grant may occur the following cycle.
- **Pointer wrap.** FIFO pointers are `$clog2(W_FIFO_DEPTH)` bits with natural wrap; the count is one bit wider.

## Test plan
- **Single burst.** Requester 0 sends AW id=3, len=3, addr=0x1000, then 4 W beats with last on beat 4. Expect `m_aw_id = {0,3}` one cycle after the grant, 4 beats forwarded, FIFO empty afterwards.
- **Round-robin.** Requesters 0 and 1 both hold AW valid for 6 cycles with `m_aw_ready = 1`. Expect grant order 0,1,0,1,0,1; W bursts are accepted in that order; a requester's W is stalled while not at the FIFO head.
- **FIFO full.** `W_FIFO_DEPTH = 4`, `m_w_ready = 0`, 6 AWs offered. Expect exactly 4 grants, then `req_aw_ready = 0` until one last-beat pop; the 5th grant follows one cycle after that pop.
- **B routing.** `m_b_id = {1, 4'h9}`, resp=2. Expect `req_b_valid = 2'b10`, `req_b_id = 9`, `req_b_resp = 2`. With `req_b_ready[1] = 0`, expect `m_b_ready = 0`.
- **Bad B ID.** `NUM_REQ = 3`, `m_b_id` prefix = 3. Expect `m_b_ready = 1`, no `req_b_valid`, and a `bad_bid_o` pulse for exactly 1 cycle.
- **Reset mid-burst.** Assert `rst_n = 0` after beat 2 of 4. Expect all outputs at their reset values immediately (asynchronous), and a fresh AW granted normally after release.
